// File: rtl/vfr_pkg.sv
// Shared types and constants for the video packet framer.
package vfr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HDR,
    CTRL_DATA,
    VID_HDR,
    VIDEO
  } state_t;

  typedef struct packed {
    logic [3:0]  interlaced;
    logic [15:0] height;
    logic [15:0] width;
  } fmt_t;

  localparam logic [3:0] CTRL_TYPE  = 4'hF;
  localparam logic [3:0] VIDEO_TYPE = 4'h0;

  localparam int MODE_ON_REQUEST  = 0;
  localparam int MODE_EVERY_FRAME = 1;
  localparam int MODE_ON_CHANGE   = 2;

  localparam int CTRL_NIBBLES = 9;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/vfr_ctrl_nibble_packer.sv
// Builds one control-packet data beat: nibble n of the format sequence goes to
// bits [3:0] of symbol (n mod SPB) in beat (n / SPB); unused symbols stay zero.
module vfr_ctrl_nibble_packer
  import vfr_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int CTRL_BEATS       = 3,
  parameter int BEAT_W           = 2,
  localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
  input  fmt_t                  i_fmt,
  input  logic [BEAT_W-1:0]     i_beat,
  output logic [DATA_WIDTH-1:0] o_data
);

  // Padded to a whole number of beats so the tail symbols read as zero.
  localparam int NIB_W = 4 * SYMBOLS_PER_BEAT * CTRL_BEATS;

  logic [NIB_W-1:0] w_nibs;

  always_comb begin
    w_nibs = '0;
    for (int k = 0; k < 4; k++) begin
      w_nibs[k*4 +: 4]     = i_fmt.width[(3-k)*4 +: 4];
      w_nibs[(k+4)*4 +: 4] = i_fmt.height[(3-k)*4 +: 4];
    end
    w_nibs[32 +: 4] = i_fmt.interlaced;
  end

  always_comb begin
    o_data = '0;
    for (int b = 0; b < CTRL_BEATS; b++) begin
      if (i_beat == BEAT_W'(b)) begin
        for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
          o_data[s*BITS_PER_SYMBOL +: 4] = w_nibs[(b*SYMBOLS_PER_BEAT + s)*4 +: 4];
        end
      end
    end
  end

endmodule

// File: rtl/vfr_ctrl_packet_inserter.sv
// Avalon-ST Video framer: prefixes each headerless pixel frame with an optional
// control packet and a video-packet header, then forwards pixels to end of frame.
//   state     | meaning
//   IDLE      | wait for sop; non-sop beats are dropped as orphans
//   CTRL_HDR  | control packet header beat (type 0xF)
//   CTRL_DATA | width/height/interlace nibble beats
//   VID_HDR   | video packet header beat (type 0x0)
//   VIDEO     | pixel pass-through until eop
module vfr_ctrl_packet_inserter
  import vfr_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int CTRL_MODE        = 0,
  localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_sop,
  input  logic                  din_eop,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop,
  input  logic                  do_control_packet,
  input  logic [15:0]           width,
  input  logic [15:0]           height,
  input  logic [3:0]            interlaced,
  output logic [15:0]           frame_count,
  output logic [7:0]            orphan_count,
  output logic                  busy
);

  localparam int CTRL_BEATS = ceil_div(CTRL_NIBBLES, SYMBOLS_PER_BEAT);
  localparam int BEAT_W     = $clog2(CTRL_BEATS);

  state_t              r_state, w_next_state;
  logic                r_pending;
  fmt_t                r_fmt, r_sent;
  logic [BEAT_W-1:0]   r_beat;
  logic [15:0]         r_frame_count;
  logic [7:0]          r_orphan_count;

  fmt_t                w_fmt_in;
  logic [DATA_WIDTH-1:0] w_ctrl_data;
  logic                w_insert, w_latch, w_orphan, w_hdr_xfer;
  logic                w_beat_inc, w_ctrl_done, w_frame_done;

  assign w_fmt_in = '{interlaced: interlaced, height: height, width: width};

  vfr_ctrl_nibble_packer #(
    .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
    .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT),
    .CTRL_BEATS      (CTRL_BEATS),
    .BEAT_W          (BEAT_W)
  ) u_packer (
    .i_fmt (r_fmt),
    .i_beat(r_beat),
    .o_data(w_ctrl_data)
  );

  always_comb begin
    case (CTRL_MODE)
      MODE_EVERY_FRAME: w_insert = 1'b1;
      MODE_ON_CHANGE:   w_insert = r_pending | (w_fmt_in != r_sent);
      default:          w_insert = r_pending;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    din_ready    = 1'b0;
    dout_valid   = 1'b0;
    dout_data    = '0;
    dout_sop     = 1'b0;
    dout_eop     = 1'b0;
    w_latch      = 1'b0;
    w_orphan     = 1'b0;
    w_hdr_xfer   = 1'b0;
    w_beat_inc   = 1'b0;
    w_ctrl_done  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        // The sop beat is held here and later forwarded as the first pixel.
        din_ready = ~din_sop;
        if (din_valid) begin
          if (din_sop) begin
            w_latch      = 1'b1;
            w_next_state = w_insert ? CTRL_HDR : VID_HDR;
          end else begin
            w_orphan = 1'b1;
          end
        end
      end
      CTRL_HDR: begin
        dout_valid     = 1'b1;
        dout_sop       = 1'b1;
        dout_data[3:0] = CTRL_TYPE;
        if (dout_ready) begin
          w_hdr_xfer   = 1'b1;
          w_next_state = CTRL_DATA;
        end
      end
      CTRL_DATA: begin
        dout_valid = 1'b1;
        dout_data  = w_ctrl_data;
        dout_eop   = (r_beat == BEAT_W'(CTRL_BEATS - 1));
        if (dout_ready) begin
          if (dout_eop) begin
            w_ctrl_done  = 1'b1;
            w_next_state = VID_HDR;
          end else begin
            w_beat_inc = 1'b1;
          end
        end
      end
      VID_HDR: begin
        dout_valid     = 1'b1;
        dout_sop       = 1'b1;
        dout_data[3:0] = VIDEO_TYPE;
        if (dout_ready) w_next_state = VIDEO;
      end
      VIDEO: begin
        dout_valid = din_valid;
        din_ready  = dout_ready;
        dout_data  = din_data;
        dout_eop   = din_eop;
        if (din_valid && dout_ready && din_eop) begin
          w_frame_done = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_pending      <= 1'b0;
      r_fmt          <= '0;
      r_sent         <= '0;
      r_beat         <= '0;
      r_frame_count  <= '0;
      r_orphan_count <= '0;
    end else begin
      r_state   <= w_next_state;
      // A request arriving with the header transfer survives for the next frame.
      r_pending <= do_control_packet | (r_pending & ~w_hdr_xfer);
      if (w_latch) r_fmt <= w_fmt_in;
      if (w_ctrl_done) r_sent <= r_fmt;
      if (w_hdr_xfer) r_beat <= '0;
      else if (w_beat_inc) r_beat <= r_beat + BEAT_W'(1);
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      if (w_orphan && (r_orphan_count != 8'hFF)) r_orphan_count <= r_orphan_count + 8'd1;
    end
  end

  assign frame_count  = r_frame_count;
  assign orphan_count = r_orphan_count;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_vfr_ctrl_packet_inserter.sv
// Bench for the video packet framer: three configurations driven with random
// handshakes and compared beat-by-beat against an expected framed stream.
module tb_vfr_ctrl_packet_inserter;

  localparam int N = 3;

  typedef struct packed {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } obeat_t;

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
    logic        has_fmt;
    logic [15:0] w;
    logic [15:0] h;
    logic [3:0]  i;
  } ibeat_t;

  int cfg_bps[N]  = '{8, 8, 6};
  int cfg_spb[N]  = '{3, 1, 4};
  int cfg_mode[N] = '{0, 2, 1};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst[N];
  logic        din_valid[N], din_sop[N], din_eop[N], dout_ready[N], req[N];
  logic [23:0] din_data[N];
  logic [15:0] width[N], height[N];
  logic [3:0]  il[N];

  logic        rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, os_a, os_b, os_c;
  logic        oe_a, oe_b, oe_c, bz_a, bz_b, bz_c;
  logic [23:0] od_a, od_c;
  logic [7:0]  od_b;
  logic [15:0] fc_a, fc_b, fc_c;
  logic [7:0]  oc_a, oc_b, oc_c;

  logic        o_rdy[N], o_valid[N], o_sop[N], o_eop[N], o_busy[N];
  logic [23:0] o_data[N];
  logic [15:0] o_fc[N];
  logic [7:0]  o_oc[N];

  always_comb begin
    o_rdy   = '{rdy_a, rdy_b, rdy_c};
    o_valid = '{ov_a, ov_b, ov_c};
    o_sop   = '{os_a, os_b, os_c};
    o_eop   = '{oe_a, oe_b, oe_c};
    o_busy  = '{bz_a, bz_b, bz_c};
    o_data  = '{od_a, {16'h0, od_b}, od_c};
    o_fc    = '{fc_a, fc_b, fc_c};
    o_oc    = '{oc_a, oc_b, oc_c};
  end

  vfr_ctrl_packet_inserter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .CTRL_MODE(0)) u_a (
    .clock(clock), .reset(rst[0]), .din_valid(din_valid[0]), .din_ready(rdy_a),
    .din_data(din_data[0]), .din_sop(din_sop[0]), .din_eop(din_eop[0]),
    .dout_valid(ov_a), .dout_ready(dout_ready[0]), .dout_data(od_a), .dout_sop(os_a),
    .dout_eop(oe_a), .do_control_packet(req[0]), .width(width[0]), .height(height[0]),
    .interlaced(il[0]), .frame_count(fc_a), .orphan_count(oc_a), .busy(bz_a));

  vfr_ctrl_packet_inserter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1), .CTRL_MODE(2)) u_b (
    .clock(clock), .reset(rst[1]), .din_valid(din_valid[1]), .din_ready(rdy_b),
    .din_data(din_data[1][7:0]), .din_sop(din_sop[1]), .din_eop(din_eop[1]),
    .dout_valid(ov_b), .dout_ready(dout_ready[1]), .dout_data(od_b), .dout_sop(os_b),
    .dout_eop(oe_b), .do_control_packet(req[1]), .width(width[1]), .height(height[1]),
    .interlaced(il[1]), .frame_count(fc_b), .orphan_count(oc_b), .busy(bz_b));

  vfr_ctrl_packet_inserter #(.BITS_PER_SYMBOL(6), .SYMBOLS_PER_BEAT(4), .CTRL_MODE(1)) u_c (
    .clock(clock), .reset(rst[2]), .din_valid(din_valid[2]), .din_ready(rdy_c),
    .din_data(din_data[2]), .din_sop(din_sop[2]), .din_eop(din_eop[2]),
    .dout_valid(ov_c), .dout_ready(dout_ready[2]), .dout_data(od_c), .dout_sop(os_c),
    .dout_eop(oe_c), .do_control_packet(req[2]), .width(width[2]), .height(height[2]),
    .interlaced(il[2]), .frame_count(fc_c), .orphan_count(oc_c), .busy(bz_c));

  int checks = 0;
  int failures = 0;

  ibeat_t src_q[$];
  obeat_t exp_q[$];
  obeat_t obs_q[$];

  bit          pend[N];
  logic [35:0] last_fmt[N];
  int          exp_fc[N], exp_oc[N];
  bit          pulse_arm;
  int          bp_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [23:0] d, input logic s, input logic e);
    obeat_t ob;
    ob.data = d; ob.sop = s; ob.eop = e;
    exp_q.push_back(ob);
  endtask

  // Expected framed stream for one frame, from the insertion rules.
  task automatic add_frame(input int sel, input logic [15:0] w, input logic [15:0] h,
                           input logic [3:0] i, input int npix, input bit mid_sop,
                           input bit pulse_hdr);
    logic [35:0] fmt;
    logic [3:0]  nib[9];
    logic [23:0] mask, d;
    ibeat_t      ib;
    bit          ins;
    int          spb, bps, nb, idx;
    spb  = cfg_spb[sel];
    bps  = cfg_bps[sel];
    mask = 24'((25'h1 << (bps * spb)) - 25'h1);
    fmt  = {i, h, w};
    case (cfg_mode[sel])
      0:       ins = pend[sel];
      1:       ins = 1'b1;
      default: ins = pend[sel] || (fmt != last_fmt[sel]);
    endcase
    if (ins) begin
      nib[0] = w[15:12]; nib[1] = w[11:8]; nib[2] = w[7:4]; nib[3] = w[3:0];
      nib[4] = h[15:12]; nib[5] = h[11:8]; nib[6] = h[7:4]; nib[7] = h[3:0];
      nib[8] = i;
      push_exp(24'h00000F, 1'b1, 1'b0);
      nb = (9 + spb - 1) / spb;
      for (int k = 0; k < nb; k++) begin
        d = '0;
        for (int s = 0; s < spb; s++) begin
          idx = k * spb + s;
          if (idx < 9) d = d | (24'(nib[idx]) << (s * bps));
        end
        push_exp(d, 1'b0, k == nb - 1);
      end
      last_fmt[sel] = fmt;
      pend[sel] = 1'b0;
      if (pulse_hdr) begin
        pend[sel] = 1'b1;
        pulse_arm = 1'b1;
      end
    end
    push_exp(24'h0, 1'b1, 1'b0);
    for (int p = 0; p < npix; p++) begin
      ib.data = 24'($urandom) & mask;
      ib.sop = (p == 0) || (mid_sop && p == 2);
      ib.eop = (p == npix - 1);
      ib.has_fmt = (p == 0);
      ib.w = w; ib.h = h; ib.i = i;
      src_q.push_back(ib);
      push_exp(ib.data, 1'b0, ib.eop);
    end
    exp_fc[sel]++;
  endtask

  task automatic add_orphans(input int sel, input int n);
    ibeat_t ib;
    for (int k = 0; k < n; k++) begin
      ib.data = 24'($urandom); ib.sop = 1'b0; ib.eop = 1'($urandom);
      ib.has_fmt = 1'b0; ib.w = '0; ib.h = '0; ib.i = '0;
      src_q.push_back(ib);
    end
    exp_oc[sel] = (exp_oc[sel] + n > 255) ? 255 : exp_oc[sel] + n;
  endtask

  task automatic pulse_req(input int sel);
    req[sel] = 1'b1;
    @(posedge clock); #1;
    req[sel] = 1'b0;
    pend[sel] = 1'b1;
  endtask

  // Drives src_q into one instance and records every output transfer.
  task automatic run(input int sel, input int stop_n, input string tag);
    ibeat_t hd;
    int cyc;
    bit in_x, tog, done;
    cyc = 0; tog = 1'b0; done = 1'b0;
    while (!done && cyc < 5000) begin
      if (src_q.size() > 0) begin
        hd = src_q[0];
        din_valid[sel] = ($urandom_range(0, 3) != 0);
        din_data[sel] = hd.data; din_sop[sel] = hd.sop; din_eop[sel] = hd.eop;
        if (hd.has_fmt) begin
          width[sel] = hd.w; height[sel] = hd.h; il[sel] = hd.i;
        end else begin
          width[sel] = 16'($urandom); height[sel] = 16'($urandom); il[sel] = 4'($urandom);
        end
      end else begin
        din_valid[sel] = 1'b0; din_sop[sel] = 1'b0; din_eop[sel] = 1'b0;
      end
      tog = ~tog;
      dout_ready[sel] = (bp_mode == 1) ? tog : (bp_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
      req[sel] = 1'b0;
      if (pulse_arm && o_valid[sel] && o_sop[sel] && o_data[sel][3:0] == 4'hF) begin
        dout_ready[sel] = 1'b1;
        req[sel] = 1'b1;
        pulse_arm = 1'b0;
      end
      @(negedge clock);
      in_x = din_valid[sel] && o_rdy[sel];
      if (o_valid[sel] && dout_ready[sel]) begin
        obs_q.push_back('{data: o_data[sel], sop: o_sop[sel], eop: o_eop[sel]});
      end
      if (o_valid[sel] && o_sop[sel]) chk({tag, "_hdr_din_ready"}, 64'(o_rdy[sel]), 64'd0);
      @(posedge clock); #1;
      if (in_x) void'(src_q.pop_front());
      cyc++;
      if (stop_n > 0) done = (obs_q.size() >= stop_n);
      else done = (src_q.size() == 0) && !o_busy[sel] && (obs_q.size() >= exp_q.size());
    end
    din_valid[sel] = 1'b0; din_sop[sel] = 1'b0; din_eop[sel] = 1'b0;
    dout_ready[sel] = 1'b0; req[sel] = 1'b0;
    chk({tag, "_completed"}, 64'(done), 64'd1);
  endtask

  task automatic compare(input int sel, input string tag);
    chk({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk($sformatf("%s_beat%0d", tag, k), 64'(obs_q[k]), 64'(exp_q[k]));
    chk({tag, "_frame_count"}, 64'(o_fc[sel]), 64'(exp_fc[sel]));
    chk({tag, "_orphan_count"}, 64'(o_oc[sel]), 64'(exp_oc[sel]));
    chk({tag, "_busy"}, 64'(o_busy[sel]), 64'd0);
    obs_q.delete(); exp_q.delete(); src_q.delete();
  endtask

  task automatic check_idle(input int sel, input string tag);
    chk({tag, "_busy"}, 64'(o_busy[sel]), 64'd0);
    chk({tag, "_dout_valid"}, 64'(o_valid[sel]), 64'd0);
    chk({tag, "_din_ready"}, 64'(o_rdy[sel]), 64'd1);
    chk({tag, "_frame_count"}, 64'(o_fc[sel]), 64'd0);
    chk({tag, "_orphan_count"}, 64'(o_oc[sel]), 64'd0);
  endtask

  initial begin
    logic [23:0] lit_a[4];
    logic [23:0] lit_b[9];
    int stop;
    lit_a = '{24'h00000F, 24'h020300, 24'h010000, 24'h03000E};
    lit_b = '{24'h0, 24'h3, 24'h2, 24'h0, 24'h0, 24'h1, 24'hE, 24'h0, 24'h3};
    pulse_arm = 1'b0;
    bp_mode = 2;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; din_valid[k] = 1'b0; din_sop[k] = 1'b0; din_eop[k] = 1'b0;
      dout_ready[k] = 1'b0; req[k] = 1'b0; din_data[k] = '0;
      width[k] = '0; height[k] = '0; il[k] = '0;
      pend[k] = 1'b0; last_fmt[k] = '0; exp_fc[k] = 0; exp_oc[k] = 0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    for (int k = 0; k < N; k++) check_idle(k, $sformatf("reset%0d", k));

    // Requested control packet, SPB=3.
    pulse_req(0);
    add_frame(0, 16'd800, 16'd480, 4'd3, 4, 1'b0, 1'b0);
    run(0, 0, "t1");
    if (obs_q.size() >= 5) begin
      for (int k = 0; k < 4; k++) chk($sformatf("t1_ctrl%0d", k), 64'(obs_q[k].data), 64'(lit_a[k]));
      chk("t1_ctrl_sop", 64'(obs_q[0].sop), 64'd1);
      chk("t1_ctrl_eop", 64'(obs_q[3].eop), 64'd1);
    end
    compare(0, "t1");

    // No request: video header and pixels only; stray mid-frame sop.
    bp_mode = 0;
    add_frame(0, 16'd1024, 16'd768, 4'd0, 5, 1'b1, 1'b0);
    run(0, 0, "t2");
    compare(0, "t2");

    // Orphans, then a request landing on the control header transfer.
    add_orphans(0, 3);
    run(0, 0, "t3o");
    compare(0, "t3o");
    pulse_req(0);
    add_frame(0, 16'd320, 16'd240, 4'd1, 3, 1'b0, 1'b1);
    run(0, 0, "t3a");
    compare(0, "t3a");
    add_frame(0, 16'd320, 16'd240, 4'd1, 2, 1'b0, 1'b0);
    run(0, 0, "t3b");
    compare(0, "t3b");

    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) != 0) pulse_req(0);
      add_orphans(0, $urandom_range(0, 2));
      add_frame(0, 16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(1, 6),
                1'($urandom), 1'b0);
      run(0, 0, "rndA");
      compare(0, "rndA");
    end

    // SPB=1, mode 2, toggling back-pressure.
    bp_mode = 1;
    add_frame(1, 16'd800, 16'd480, 4'd3, 3, 1'b0, 1'b0);
    run(1, 0, "b1");
    if (obs_q.size() >= 10) begin
      for (int k = 0; k < 9; k++) chk($sformatf("b1_nib%0d", k), 64'(obs_q[k+1].data), 64'(lit_b[k]));
      chk("b1_ctrl_eop", 64'(obs_q[9].eop), 64'd1);
    end
    compare(1, "b1");
    add_frame(1, 16'd800, 16'd480, 4'd3, 3, 1'b0, 1'b0);
    run(1, 0, "b2");
    compare(1, "b2");
    add_frame(1, 16'd1024, 16'd768, 4'd0, 4, 1'b0, 1'b0);
    run(1, 0, "b3");
    compare(1, "b3");
    bp_mode = 0;
    for (int f = 0; f < 5; f++) begin
      if ($urandom_range(0, 2) == 0) pulse_req(1);
      if ($urandom_range(0, 1) != 0)
        add_frame(1, 16'd1024, 16'd768, 4'd0, $urandom_range(1, 5), 1'b0, 1'b0);
      else
        add_frame(1, 16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(1, 5), 1'b0, 1'b0);
      run(1, 0, "rndB");
      compare(1, "rndB");
    end
    add_orphans(1, 260);
    run(1, 0, "bsat");
    compare(1, "bsat");

    // BPS=6, SPB=4, every-frame insertion.
    for (int f = 0; f < 4; f++) begin
      add_frame(2, 16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(1, 5),
                1'($urandom), 1'b0);
      run(2, 0, "rndC");
      compare(2, "rndC");
    end

    // Reset after two pixels of a frame.
    bp_mode = 2;
    add_frame(0, 16'd64, 16'd32, 4'd2, 6, 1'b0, 1'b0);
    stop = exp_q.size() - 4;
    run(0, stop, "rst");
    rst[0] = 1'b1;
    @(posedge clock); #1;
    rst[0] = 1'b0;
    check_idle(0, "midrst");
    obs_q.delete(); exp_q.delete(); src_q.delete();
    pend[0] = 1'b0; last_fmt[0] = '0; exp_fc[0] = 0; exp_oc[0] = 0;
    add_frame(0, 16'd64, 16'd32, 4'd2, 3, 1'b0, 1'b0);
    run(0, 0, "postrst");
    compare(0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vfr_ctrl_packet_inserter.md
Name: vfr_ctrl_packet_inserter

Overview:
- Avalon-ST Video packet framer between the frame reader's pixel stream and the stream output stage.
- Pixel stream arrives headerless; this block emits an optional control packet (type 0xF: width, height, interlace), then a video-packet header beat (type 0x0), then forwards pixels to end of frame.
- Parametrised successor to the fixed 3x8-bit encoder: any symbols-per-beat 1..4, selectable insertion policy, frame counter, error counter.

Parameters:
- BITS_PER_SYMBOL, 8, symbol width; legal range 4..16.
- SYMBOLS_PER_BEAT, 3, symbols per beat; legal range 1..4.
- CTRL_MODE, 0, insertion policy: 0 = on request; 1 = every frame; 2 = on request or when the latched format differs from the last one sent.
- Derived constants: DATA_WIDTH = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT; CTRL_BEATS = ceil(9/SYMBOLS_PER_BEAT).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- din_valid / din_ready  in / out  1 / 1  pixel stream handshake.
- din_data  in  DATA_WIDTH  pixel data.
- din_sop, din_eop  in  1  first / last pixel of a frame.
- dout_valid / dout_ready  out / in  1 / 1  framed stream handshake.
- dout_data  out  DATA_WIDTH  framed stream data.
- dout_sop, dout_eop  out  1  packet boundaries.
- do_control_packet  in  1  one-cycle request pulse.
- width, height  in  16  next format.
- interlaced  in  4  next format.
- frame_count  out  16  video packets completed; wraps.
- orphan_count  out  8  discarded non-SOP beats; saturates at 255.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, ports named clock and reset.
- Reset values: state IDLE, pending 0, last-sent format 0, counters 0. With state IDLE, dout_valid 0, busy 0, din_ready 1.
- Handshake: a beat transfers when valid and ready are both high (ready latency 0). dout_* signals are combinational from registered state and counters; nothing else registers them.
- Request latch: pending set by do_control_packet; cleared when the control header beat transfers. A pulse in the clearing cycle keeps pending at 1.
- IDLE:
  - din_ready = ~din_sop.
  - din_valid & ~din_sop: beat consumed and dropped, orphan_count++.
  - din_valid & din_sop: latch width, height and interlaced; decide insertion.
    - Mode 0: pending.
    - Mode 1: always.
    - Mode 2: pending OR latched format != last-sent format.
  - Next state CTRL_HDR if inserting, else VID_HDR.
- CTRL_HDR:
  - dout_valid 1, dout_sop 1, symbol 0 = 0xF, all other bits 0.
  - On transfer: beat counter = 0, go to CTRL_DATA.
- CTRL_DATA:
  - Nibble sequence: w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], interlaced.
  - Beat k carries nibbles k*SPB .. k*SPB+SPB-1. Each nibble sits in bits [3:0] of its symbol; symbol 0 is in the LSBs; upper symbol bits 0; symbols past nibble 8 are 0.
  - dout_eop 1 on beat CTRL_BEATS-1; on that transfer, last-sent format = latched format, go to VID_HDR.
- VID_HDR:
  - dout_valid 1, dout_sop 1, data 0.
  - On transfer: go to VIDEO.
- VIDEO (combinational pass-through):
  - dout_valid = din_valid, din_ready = dout_ready, dout_data = din_data, dout_eop = din_eop, dout_sop 0.
  - The held SOP beat is forwarded as first pixel.
  - din_sop on a later beat is forwarded as data with sop suppressed; no restart.
  - On eop transfer: frame_count++, go to IDLE.
- Latched format is stable for the whole frame; input changes mid-frame take effect at the next frame.
- Reset mid-packet aborts immediately. The downstream stage sees a truncated packet without eop and must resynchronise on the next sop.

Decomposition:
- Shared package vfr_pkg:
  - State enum {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, VIDEO}.
  - Type nibbles CTRL_TYPE=4'hF, VIDEO_TYPE=4'h0.
  - CTRL_MODE encodings.
  - ceil-div function for CTRL_BEATS.
- One sub-module: vfr_ctrl_nibble_packer. Combinational; maps the latched format plus beat index to one control-data beat.

Test Plan:
- Format and packing (SPB=3, BPS=8, mode 0): pulse request; width 800, height 480, interlaced 3; 4-pixel frame.
  - Required beats: 0x00000F (sop); 0x020300; 0x010000; 0x03000E (eop).
  - Then 0x000000 (sop), then 4 pixels, last with eop; frame_count = 1.
- No request (mode 0): next frame emits the video header plus pixels only; no 0x00000F beat.
- Back-pressure (SPB=1): dout_ready toggled 1/0 every cycle.
  - Control data is exactly 9 beats: 0,3,2,0,0,1,E,0,3 with eop on the 9th.
  - No beat lost or duplicated; din_ready low until VIDEO.
- Mode 2: two frames with the same format, then 1024x768.
  - Control packet on frame 1 (last-sent reset value 0 differs), none on frame 2, one on frame 3.
- Orphans: 3 beats without sop in IDLE.
  - All consumed, orphan_count = 3, no output.
  - Request pulse in the same cycle as the control header transfer leaves pending = 1, so the next frame also gets a control packet.
- Reset mid-VIDEO: reset asserted after 2 pixels.
  - Next cycle: busy 0, dout_valid 0, counters 0, din_ready 1.
